sprite_compositor: RTL and testbench

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

---
 rtl/display_pkg.sv | 17 +
 rtl/sprite_compositor_if.sv | 26 ++
 rtl/sprite_compositor_hit.sv | 24 ++
 rtl/sprite_compositor.sv | 166 ++++++++++++++++
 tb/tb_sprite_compositor.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display constants and sprite record type
package display_pkg;

   localparam int TOTAL_WIDTH  = 1024;
   localparam int TOTAL_HEIGHT = 768;
   localparam int COLOR_W      = 24;

   typedef struct packed {
      logic [10:0]        x;
      logic [9:0]         y;
      logic [7:0]         w;
      logic [7:0]         h;
      logic [COLOR_W-1:0] color;
      logic               en;
   } sprite_t;

endpackage

// File: rtl/sprite_compositor_if.sv
// rtl/sprite_compositor_if.sv - sprite-update handshake bundle
interface sprite_compositor_if #(
   parameter int NUM_SPRITES = 4
);
   localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

   logic             upd_valid;
   logic             upd_ready;
   logic [IDX_W-1:0] upd_idx;
   logic [10:0]      upd_x;
   logic [9:0]       upd_y;
   logic [7:0]       upd_w;
   logic [7:0]       upd_h;
   logic [23:0]      upd_color;
   logic             upd_en;

   modport master (
      output upd_valid, upd_idx, upd_x, upd_y, upd_w, upd_h, upd_color, upd_en,
      input  upd_ready
   );

   modport slave (
      input  upd_valid, upd_idx, upd_x, upd_y, upd_w, upd_h, upd_color, upd_en,
      output upd_ready
   );
endinterface

// File: rtl/sprite_compositor_hit.sv
// rtl/sprite_compositor_hit.sv - rectangle hit test for one sprite channel
module sprite_hit (
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic [10:0] x,
   input  logic [9:0]  y,
   input  logic [7:0]  w,
   input  logic [7:0]  h,
   input  logic        en,
   output logic        hit
);
   // End coordinates carry one extra bit so a sprite hanging off the right
   // or bottom edge is clipped instead of wrapping to column/row 0.
   logic [11:0] x_end;
   logic [10:0] y_end;

   assign x_end = {1'b0, x} + {4'b0, w};
   assign y_end = {1'b0, y} + {3'b0, h};

   // A zero width/height gives an empty range, so it never hits.
   assign hit = en
              && (hcount >= x) && ({1'b0, hcount} < x_end)
              && (vcount >= y) && ({1'b0, vcount} < y_end);
endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - double-buffered sprite overlay, 2-cycle pixel pipe; option SPRITE_COMPOSITOR_ALPHA_BLEND_EN
module sprite_compositor
   import display_pkg::*;
#(
   parameter int                 NUM_SPRITES = 4,
   parameter int                 ALPHA_M     = 1,
   parameter int                 ALPHA_LOG2  = 2,
   parameter logic [COLOR_W-1:0] BG_COLOR    = 24'h00_00_00
)(
   input  logic               vclock,
   input  logic               reset_n,
   input  logic [10:0]        hcount,
   input  logic [9:0]         vcount,
   input  logic               hsync,
   input  logic               vsync,
   input  logic               blank,
   sprite_compositor_if.slave upd,
   output logic               phsync,
   output logic               pvsync,
   output logic               pblank,
   output logic [COLOR_W-1:0] pixel,
   output logic               frame_commit
);
   localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

   if (NUM_SPRITES < 1 || NUM_SPRITES > 8 || ALPHA_M < 0 || ALPHA_M >= (1 << ALPHA_LOG2)) begin : g_bad_cfg
      $error("sprite_compositor: illegal NUM_SPRITES/ALPHA_M/ALPHA_LOG2");
   end

   sprite_t shadow_q [NUM_SPRITES];
   sprite_t active_q [NUM_SPRITES];
   sprite_t upd_rec;
   logic    vs_q, commit_q, rdy_q;
   logic    vs_fall, upd_fire;

   assign vs_fall        = vs_q & ~vsync;
   assign upd.upd_ready  = rdy_q & ~commit_q;
   assign frame_commit   = commit_q;
   assign upd_fire       = upd.upd_valid & upd.upd_ready;
   assign upd_rec        = '{x: upd.upd_x, y: upd.upd_y, w: upd.upd_w, h: upd.upd_h,
                             color: upd.upd_color, en: upd.upd_en};

   // vsync falling-edge detect; the commit cycle follows the detection cycle
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) begin
         vs_q     <= 1'b0;
         commit_q <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         vs_q     <= vsync;
         commit_q <= vs_fall;
         rdy_q    <= 1'b1;
      end
   end

   // Shadow writes from the update port; shadow-to-active copy in the commit cycle
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (upd_fire && upd.upd_idx == IDX_W'(i)) shadow_q[i] <= upd_rec;
            if (commit_q)                            active_q[i] <= shadow_q[i];
         end
      end
   end

   logic [NUM_SPRITES-1:0] hit_c, hit_q;
   logic [COLOR_W-1:0]     col_q [NUM_SPRITES];
   logic                   blank1_q, hs1_q, vs1_q;

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
      sprite_hit u_hit (
         .hcount (hcount),
         .vcount (vcount),
         .x      (active_q[g].x),
         .y      (active_q[g].y),
         .w      (active_q[g].w),
         .h      (active_q[g].h),
         .en     (active_q[g].en),
         .hit    (hit_c[g])
      );
   end

   // Stage 1: hit vector, colours and timing
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) begin
         hit_q    <= '0;
         blank1_q <= 1'b1;
         hs1_q    <= 1'b1;
         vs1_q    <= 1'b1;
         for (int i = 0; i < NUM_SPRITES; i++) col_q[i] <= '0;
      end else begin
         hit_q    <= hit_c;
         blank1_q <= blank;
         hs1_q    <= hsync;
         vs1_q    <= vsync;
         for (int i = 0; i < NUM_SPRITES; i++) col_q[i] <= active_q[i].color;
      end
   end

`ifdef SPRITE_COMPOSITOR_ALPHA_BLEND_EN
   localparam int SW = 8 + ALPHA_LOG2 + 1;

   function automatic logic [7:0] blend_ch(input logic [7:0] t, input logic [7:0] s);
      logic [SW-1:0] acc;
      acc = SW'(t) * SW'(ALPHA_M) + SW'(s) * SW'((1 << ALPHA_LOG2) - ALPHA_M);
      return 8'(acc >> ALPHA_LOG2);
   endfunction

   logic [COLOR_W-1:0] sec_c;
   logic               found2;
`endif

   logic [COLOR_W-1:0] top_c, res_c;
   logic               found1;

   // Priority resolve: lowest hitting index is on top
   always_comb begin
      top_c  = BG_COLOR;
      found1 = 1'b0;
`ifdef SPRITE_COMPOSITOR_ALPHA_BLEND_EN
      sec_c  = '0;
      found2 = 1'b0;
`endif
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (hit_q[i]) begin
            if (!found1) begin
               top_c  = col_q[i];
               found1 = 1'b1;
            end
`ifdef SPRITE_COMPOSITOR_ALPHA_BLEND_EN
            else if (!found2) begin
               sec_c  = col_q[i];
               found2 = 1'b1;
            end
`endif
         end
      end
`ifdef SPRITE_COMPOSITOR_ALPHA_BLEND_EN
      res_c = found2 ? {blend_ch(top_c[23:16], sec_c[23:16]),
                        blend_ch(top_c[15:8],  sec_c[15:8]),
                        blend_ch(top_c[7:0],   sec_c[7:0])} : top_c;
`else
      res_c = top_c;
`endif
   end

   // Stage 2: resolved pixel, forced black while blanking
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) begin
         pixel  <= '0;
         phsync <= 1'b1;
         pvsync <= 1'b1;
         pblank <= 1'b1;
      end else begin
         pixel  <= blank1_q ? '0 : res_c;
         phsync <= hs1_q;
         pvsync <= vs1_q;
         pblank <= blank1_q;
      end
   end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - randomized self-checking bench for sprite_compositor
module tb_sprite_compositor;
   localparam int          NS = 4;
   localparam int          AM = 1;
   localparam int          AL = 2;
   localparam logic [23:0] BG = 24'h000000;

   logic        vclock = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] hcount = '0;
   logic [9:0]  vcount = '0;
   logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b0;
   logic        phsync, pvsync, pblank, frame_commit;
   logic [23:0] pixel;

   sprite_compositor_if #(.NUM_SPRITES(NS)) upd_if ();

   sprite_compositor #(
      .NUM_SPRITES(NS), .ALPHA_M(AM), .ALPHA_LOG2(AL), .BG_COLOR(BG)
   ) dut (
      .vclock(vclock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
      .hsync(hsync), .vsync(vsync), .blank(blank), .upd(upd_if),
      .phsync(phsync), .pvsync(pvsync), .pblank(pblank), .pixel(pixel),
      .frame_commit(frame_commit)
   );

   always #5 vclock = ~vclock;

   int checks = 0;
   int errors = 0;

   // reference model: shadow and active sprite tables
   int          sh_x[NS], sh_y[NS], sh_w[NS], sh_h[NS], sh_en[NS];
   logic [23:0] sh_c[NS];
   int          ac_x[NS], ac_y[NS], ac_w[NS], ac_h[NS], ac_en[NS];
   logic [23:0] ac_c[NS];

   task automatic tick();
      @(posedge vclock);
      #1;
   endtask

   function automatic void model_clear();
      for (int i = 0; i < NS; i++) begin
         sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0; sh_en[i] = 0; sh_c[i] = '0;
         ac_x[i] = 0; ac_y[i] = 0; ac_w[i] = 0; ac_h[i] = 0; ac_en[i] = 0; ac_c[i] = '0;
      end
   endfunction

   function automatic void model_commit();
      for (int i = 0; i < NS; i++) begin
         ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_w[i] = sh_w[i];
         ac_h[i] = sh_h[i]; ac_en[i] = sh_en[i]; ac_c[i] = sh_c[i];
      end
   endfunction

   function automatic logic [23:0] ref_pixel(input int h, input int v, input bit bl);
      int          hits[$];
      logic [23:0] t, s, r;
      int          tv, sv;
      if (bl) return 24'h0;
      for (int i = 0; i < NS; i++)
         if (ac_en[i] != 0 && h >= ac_x[i] && h < ac_x[i] + ac_w[i]
             && v >= ac_y[i] && v < ac_y[i] + ac_h[i])
            hits.push_back(i);
      if (hits.size() == 0) return BG;
      t = ac_c[hits[0]];
`ifdef SPRITE_COMPOSITOR_ALPHA_BLEND_EN
      if (hits.size() >= 2) begin
         s = ac_c[hits[1]];
         for (int ch = 0; ch < 3; ch++) begin
            tv = int'(t[8*ch +: 8]);
            sv = int'(s[8*ch +: 8]);
            r[8*ch +: 8] = 8'((tv * AM + sv * ((1 << AL) - AM)) >> AL);
         end
         return r;
      end
`endif
      s = '0;
      r = '0;
      tv = 0;
      sv = 0;
      return t;
   endfunction

   task automatic probe(input int h, input int v, input bit bl, output logic [23:0] px);
      hcount = 11'(h);
      vcount = 10'(v);
      blank  = bl;
      tick();
      blank  = 1'b0;
      tick();
      px = pixel;
   endtask

   task automatic write_sprite(input int idx, input int x, input int y, input int w, input int h,
                               input logic [23:0] c, input bit en);
      int n = 0;
      upd_if.upd_valid = 1'b1;
      upd_if.upd_idx   = 2'(idx);
      upd_if.upd_x     = 11'(x);
      upd_if.upd_y     = 10'(y);
      upd_if.upd_w     = 8'(w);
      upd_if.upd_h     = 8'(h);
      upd_if.upd_color = c;
      upd_if.upd_en    = en;
      while (upd_if.upd_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (upd_if.upd_ready !== 1'b1) begin
         errors++;
         $display("FAIL write_ready_timeout: upd_ready=%b required 1", upd_if.upd_ready);
      end
      tick();
      upd_if.upd_valid = 1'b0;
      sh_x[idx] = x; sh_y[idx] = y; sh_w[idx] = w; sh_h[idx] = h; sh_c[idx] = c; sh_en[idx] = int'(en);
   endtask

   task automatic vsync_commit();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      checks++;
      if (frame_commit !== 1'b1 || upd_if.upd_ready !== 1'b0 || pvsync !== 1'b1) begin
         errors++;
         $display("FAIL commit_cycle: frame_commit=%b upd_ready=%b pvsync=%b required 1 0 1",
                  frame_commit, upd_if.upd_ready, pvsync);
      end
      tick();
      model_commit();
      checks++;
      if (frame_commit !== 1'b0 || upd_if.upd_ready !== 1'b1 || pvsync !== 1'b0) begin
         errors++;
         $display("FAIL after_commit: frame_commit=%b upd_ready=%b pvsync=%b required 0 1 0",
                  frame_commit, upd_if.upd_ready, pvsync);
      end
      vsync = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge vclock);
      #1;
      checks++;
      if (pixel !== 24'h0 || phsync !== 1'b1 || pvsync !== 1'b1 || pblank !== 1'b1
          || frame_commit !== 1'b0 || upd_if.upd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: pixel=%h hs=%b vs=%b bl=%b fc=%b rdy=%b required 000000 1 1 1 0 0",
                  pixel, phsync, pvsync, pblank, frame_commit, upd_if.upd_ready);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (upd_if.upd_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: upd_ready=%b required 0", upd_if.upd_ready);
      end
      tick();
      checks++;
      if (upd_if.upd_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_first_cycle: upd_ready=%b required 1", upd_if.upd_ready);
      end
   endtask

   task automatic test_basic_draw();
      logic [23:0] px;
      write_sprite(0, 100, 50, 16, 16, 24'hFF0000, 1'b1);
      vsync_commit();
      hcount = 11'd99; vcount = 10'd50;
      tick();
      hcount = 11'd100;
      tick();
      checks++;
      if (pixel !== 24'h000000) begin
         errors++;
         $display("FAIL latency_h99: pixel=%h required 000000", pixel);
      end
      hcount = 11'd116;
      tick();
      checks++;
      if (pixel !== 24'hFF0000) begin
         errors++;
         $display("FAIL draw_h100: pixel=%h required FF0000", pixel);
      end
      tick();
      checks++;
      if (pixel !== 24'h000000) begin
         errors++;
         $display("FAIL draw_h116: pixel=%h required 000000", pixel);
      end
      probe(115, 65, 1'b0, px);
      checks++;
      if (px !== 24'hFF0000) begin
         errors++;
         $display("FAIL draw_corner: pixel=%h required FF0000", px);
      end
   endtask

   task automatic test_overlap();
      logic [23:0] px, exp_ov;
      write_sprite(0, 100, 50, 16, 16, 24'hFFFFFF, 1'b1);
      write_sprite(1, 108, 58, 16, 16, 24'hFF0000, 1'b1);
      vsync_commit();
`ifdef SPRITE_COMPOSITOR_ALPHA_BLEND_EN
      exp_ov = 24'hFF3F3F;
`else
      exp_ov = 24'hFFFFFF;
`endif
      probe(110, 60, 1'b0, px);
      checks++;
      if (px !== exp_ov) begin
         errors++;
         $display("FAIL overlap: pixel=%h required %h", px, exp_ov);
      end
      probe(120, 70, 1'b0, px);
      checks++;
      if (px !== 24'hFF0000) begin
         errors++;
         $display("FAIL overlap_second_only: pixel=%h required FF0000", px);
      end
   endtask

   task automatic test_tear_free();
      logic [23:0] px;
      write_sprite(0, 200, 50, 16, 16, 24'hFFFFFF, 1'b1);
      probe(105, 55, 1'b0, px);
      checks++;
      if (px !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL tear_old_pos: pixel=%h required FFFFFF", px);
      end
      probe(205, 55, 1'b0, px);
      checks++;
      if (px !== 24'h000000) begin
         errors++;
         $display("FAIL tear_new_early: pixel=%h required 000000", px);
      end
      vsync_commit();
      probe(205, 55, 1'b0, px);
      checks++;
      if (px !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL tear_new_pos: pixel=%h required FFFFFF", px);
      end
      probe(105, 55, 1'b0, px);
      checks++;
      if (px !== 24'h000000) begin
         errors++;
         $display("FAIL tear_old_gone: pixel=%h required 000000", px);
      end
   endtask

   task automatic test_hold_across_commit();
      logic [23:0] px;
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      upd_if.upd_valid = 1'b1;
      upd_if.upd_idx = 2'd0; upd_if.upd_x = 11'd300; upd_if.upd_y = 10'd50;
      upd_if.upd_w = 8'd16; upd_if.upd_h = 8'd16; upd_if.upd_color = 24'hFFFFFF; upd_if.upd_en = 1'b1;
      #1;
      checks++;
      if (upd_if.upd_ready !== 1'b0 || frame_commit !== 1'b1) begin
         errors++;
         $display("FAIL hold_commit_cycle: upd_ready=%b frame_commit=%b required 0 1",
                  upd_if.upd_ready, frame_commit);
      end
      tick();
      model_commit();
      checks++;
      if (upd_if.upd_ready !== 1'b1 || frame_commit !== 1'b0) begin
         errors++;
         $display("FAIL hold_next_cycle: upd_ready=%b frame_commit=%b required 1 0",
                  upd_if.upd_ready, frame_commit);
      end
      tick();
      upd_if.upd_valid = 1'b0;
      vsync = 1'b1;
      sh_x[0] = 300; sh_y[0] = 50; sh_w[0] = 16; sh_h[0] = 16; sh_c[0] = 24'hFFFFFF; sh_en[0] = 1;
      probe(305, 55, 1'b0, px);
      checks++;
      if (px !== 24'h000000) begin
         errors++;
         $display("FAIL hold_not_yet: pixel=%h required 000000", px);
      end
      vsync_commit();
      probe(305, 55, 1'b0, px);
      checks++;
      if (px !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL hold_applied: pixel=%h required FFFFFF", px);
      end
   endtask

   task automatic test_edge_clip();
      logic [23:0] px, exp_px;
      write_sprite(2, 1020, 100, 16, 16, 24'h00FF00, 1'b1);
      vsync_commit();
      for (int h = 1018; h < 1024; h++) begin
         probe(h, 105, 1'b0, px);
         exp_px = (h >= 1020) ? 24'h00FF00 : 24'h000000;
         checks++;
         if (px !== exp_px) begin
            errors++;
            $display("FAIL clip_right h=%0d: pixel=%h required %h", h, px, exp_px);
         end
      end
      for (int h = 0; h < 12; h++) begin
         probe(h, 105, 1'b0, px);
         checks++;
         if (px !== 24'h000000) begin
            errors++;
            $display("FAIL clip_wrap h=%0d: pixel=%h required 000000", h, px);
         end
      end
   endtask

   task automatic test_sync_delay();
      hcount = 11'd1021; vcount = 10'd105;
      hsync = 1'b0; blank = 1'b1;
      tick();
      hsync = 1'b1; blank = 1'b0;
      checks++;
      if (phsync !== 1'b1 || pblank !== 1'b0) begin
         errors++;
         $display("FAIL sync_one_cycle: phsync=%b pblank=%b required 1 0", phsync, pblank);
      end
      tick();
      checks++;
      if (phsync !== 1'b0 || pblank !== 1'b1 || pixel !== 24'h0) begin
         errors++;
         $display("FAIL sync_two_cycles: phsync=%b pblank=%b pixel=%h required 0 1 000000",
                  phsync, pblank, pixel);
      end
      tick();
      checks++;
      if (phsync !== 1'b1 || pblank !== 1'b0 || pixel !== 24'h00FF00) begin
         errors++;
         $display("FAIL sync_release: phsync=%b pblank=%b pixel=%h required 1 0 00FF00",
                  phsync, pblank, pixel);
      end
   endtask

   task automatic test_random();
      logic [23:0] px, exp_px;
      int          s, h, v, x, w, y, hh;
      bit          bl;
      for (int round = 0; round < 4; round++) begin
         for (int i = 0; i < NS; i++) begin
            x  = ($urandom_range(0, 3) == 0) ? 1000 + $urandom_range(0, 23) : $urandom_range(0, 1023);
            y  = $urandom_range(0, 767);
            w  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 48);
            hh = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 48);
            write_sprite(i, x, y, w, hh, 24'($urandom), ($urandom_range(0, 4) != 0));
         end
         vsync_commit();
         for (int k = 0; k < 40; k++) begin
            s  = $urandom_range(0, NS - 1);
            h  = ac_x[s] + $urandom_range(0, ac_w[s] + 3) - 2;
            v  = ac_y[s] + $urandom_range(0, ac_h[s] + 3) - 2;
            if (h < 0) h = 0;
            if (h > 2047) h = 2047;
            if (v < 0) v = 0;
            if (v > 1023) v = 1023;
            bl = ($urandom_range(0, 7) == 0);
            probe(h, v, bl, px);
            exp_px = ref_pixel(h, v, bl);
            checks++;
            if (px !== exp_px) begin
               errors++;
               $display("FAIL random r=%0d h=%0d v=%0d blank=%0d: pixel=%h required %h",
                        round, h, v, bl, px, exp_px);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [23:0] px;
      for (int i = 0; i < NS; i++) write_sprite(i, 0, 0, 0, 0, 24'h0, 1'b0);
      write_sprite(3, 400, 300, 8, 8, 24'h0000FF, 1'b1);
      vsync_commit();
      hsync = 1'b0;
      probe(402, 302, 1'b0, px);
      checks++;
      if (px !== 24'h0000FF || phsync !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset_draw: pixel=%h phsync=%b required 0000FF 0", px, phsync);
      end
      write_sprite(0, 500, 300, 8, 8, 24'h00FFFF, 1'b1);
      reset_n = 1'b0;
      #1;
      model_clear();
      checks++;
      if (pixel !== 24'h0 || phsync !== 1'b1 || pvsync !== 1'b1 || pblank !== 1'b1
          || frame_commit !== 1'b0 || upd_if.upd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_midframe: pixel=%h hs=%b vs=%b bl=%b fc=%b rdy=%b required 000000 1 1 1 0 0",
                  pixel, phsync, pvsync, pblank, frame_commit, upd_if.upd_ready);
      end
      hsync = 1'b1;
      @(posedge vclock);
      #1;
      reset_n = 1'b1;
      tick();
      vsync_commit();
      probe(402, 302, 1'b0, px);
      checks++;
      if (px !== 24'h000000) begin
         errors++;
         $display("FAIL post_reset_old: pixel=%h required 000000", px);
      end
      probe(502, 302, 1'b0, px);
      checks++;
      if (px !== 24'h000000) begin
         errors++;
         $display("FAIL post_reset_pending: pixel=%h required 000000", px);
      end
      write_sprite(3, 400, 300, 8, 8, 24'h0000FF, 1'b1);
      vsync_commit();
      probe(402, 302, 1'b0, px);
      checks++;
      if (px !== 24'h0000FF) begin
         errors++;
         $display("FAIL post_reset_redraw: pixel=%h required 0000FF", px);
      end
   endtask

   initial begin
      upd_if.upd_valid = 1'b0;
      upd_if.upd_idx   = '0;
      upd_if.upd_x     = '0;
      upd_if.upd_y     = '0;
      upd_if.upd_w     = '0;
      upd_if.upd_h     = '0;
      upd_if.upd_color = '0;
      upd_if.upd_en    = 1'b0;
      model_clear();
      test_reset();
      test_basic_draw();
      test_overlap();
      test_tear_free();
      test_hold_across_commit();
      test_edge_clip();
      test_sync_delay();
      test_random();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
